// File: rtl/apb_event_completer.sv
// rtl/apb_event_completer.sv - APB completer with a 5-word event/status/config register window.
// Event writes raise a one-cycle pulse, bump a saturating per-channel counter and feed a level irq.
module apb_event_completer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [2:0]  WAIT_DEFAULT = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic [31:0] apb_paddr_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pready_o,
  output logic        apb_pslverr_o,
  output logic        evt_valid_o,
  output logic [1:0]  evt_id_o,
  output logic [31:0] evt_data_o,
  output logic        irq_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr_q, wdata_q;
  logic             write_q;
  logic [2:0]       wait_cnt;
  logic [2:0][31:0] evt_q;
  logic [2:0][7:0]  cnt_q;
  logic [2:0]       cfg_wait;
  logic             irq_en;

  logic [31:0] offset;
  logic [2:0]  reg_idx;
  logic        addr_err;
  logic        setup, xfer, done, wr_ok;
  logic [31:0] rdata;

  // Decode uses the address latched in setup, so a changing paddr in access is harmless.
  assign offset   = addr_q - BASE_ADDR;
  assign reg_idx  = offset[4:2];
  assign addr_err = (offset[1:0] != 2'b00) || (offset >= 32'd20);
  assign setup    = (state == IDLE) && apb_psel_i && !apb_penable_i;
  assign xfer     = (state == ACCESS) && apb_psel_i && apb_penable_i;
  assign done     = xfer && (wait_cnt == 3'd0);
  assign wr_ok    = done && write_q && !addr_err;

  always_comb begin
    state_nxt     = state;
    apb_pready_o  = 1'b0;
    apb_pslverr_o = 1'b0;
    apb_prdata_o  = '0;
    rdata         = '0;
    case (reg_idx)
      3'd0, 3'd1, 3'd2: rdata = evt_q[reg_idx[1:0]];
      3'd3:             rdata = {8'h00, cnt_q};
      3'd4:             rdata = {28'h0, irq_en, cfg_wait};
      default:          rdata = '0;
    endcase
    case (state)
      IDLE: begin
        if (setup) state_nxt = ACCESS;
      end
      ACCESS: begin
        // Dropping psel mid-transfer abandons it without completing.
        if (!apb_psel_i || done) state_nxt = IDLE;
        apb_pready_o  = done;
        apb_pslverr_o = done && addr_err;
        if (done && !write_q && !addr_err) apb_prdata_o = rdata;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      wait_cnt    <= '0;
      evt_q       <= '0;
      cnt_q       <= '0;
      cfg_wait    <= WAIT_DEFAULT;
      irq_en      <= 1'b0;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_data_o  <= '0;
      irq_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      evt_valid_o <= 1'b0;
      irq_o       <= irq_en && (cnt_q != '0);
      if (setup) begin
        addr_q   <= apb_paddr_i;
        write_q  <= apb_pwrite_i;
        wdata_q  <= apb_pwdata_i;
        wait_cnt <= cfg_wait;
      end else if (xfer && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (wr_ok) begin
        for (int i = 0; i < 3; i++) begin
          if (reg_idx == 3'(i)) begin
            evt_q[i] <= wdata_q;
            if (cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
            evt_valid_o <= 1'b1;
            evt_id_o    <= 2'(i);
            evt_data_o  <= wdata_q;
          end
          if ((reg_idx == 3'd3) && wdata_q[8*i]) cnt_q[i] <= 8'h00;
        end
        if (reg_idx == 3'd4) begin
          cfg_wait <= wdata_q[2:0];
          irq_en   <= wdata_q[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_event_completer.sv
// tb/tb_apb_event_completer.sv - randomized bench for apb_event_completer against a transaction-level model.
// Directed scenarios pin the model with literal values; random traffic follows.
module tb_apb_event_completer;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata, evt_data;
  logic        pready, pslverr, evt_valid, irq;
  logic [1:0]  evt_id;

  apb_event_completer dut (
    .clk(clk), .reset(reset),
    .apb_psel_i(psel), .apb_penable_i(penable), .apb_paddr_i(paddr),
    .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
    .apb_prdata_o(prdata), .apb_pready_o(pready), .apb_pslverr_o(pslverr),
    .evt_valid_o(evt_valid), .evt_id_o(evt_id), .evt_data_o(evt_data), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // model state after the most recent clock edge
  logic [31:0] m_evt [3];
  int          m_cnt [3];
  int          m_wait;
  bit          m_irq_en;

  // expected outputs for the current cycle
  logic        exp_pready, exp_pslverr, exp_evt_valid, exp_irq;
  logic [31:0] exp_prdata, exp_evt_data;
  logic [1:0]  exp_evt_id;

  int  n_checks = 0, n_err = 0;
  bit  chk_en = 0;
  int  dut_waits;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pready", {31'h0, pready}, {31'h0, exp_pready});
      check("pslverr", {31'h0, pslverr}, {31'h0, exp_pslverr});
      check("prdata", prdata, exp_prdata);
      check("evt_valid", {31'h0, evt_valid}, {31'h0, exp_evt_valid});
      check("evt_id", {30'h0, evt_id}, {30'h0, exp_evt_id});
      check("evt_data", evt_data, exp_evt_data);
      check("irq", {31'h0, irq}, {31'h0, exp_irq});
    end
  end

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd20);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) >> 2);
    if (idx < 3) return m_evt[idx];
    if (idx == 3) return {8'h00, 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
    return {28'h0, m_irq_en, 3'(m_wait)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_evt[i] = '0; m_cnt[i] = 0; end
    m_wait = 0; m_irq_en = 0;
    exp_pready = 0; exp_pslverr = 0; exp_prdata = '0;
    exp_evt_valid = 0; exp_evt_id = '0; exp_evt_data = '0; exp_irq = 0;
  endtask

  // Advance one clock; if done, apply the completed transfer's effect to the model.
  task automatic tick(input bit done, input logic [31:0] a, input bit w, input logic [31:0] d);
    bit irq_nxt;
    int idx;
    @(posedge clk);
    irq_nxt = m_irq_en && ((m_cnt[0] + m_cnt[1] + m_cnt[2]) != 0);
    exp_evt_valid = 0;
    if (done && w && !is_err(a)) begin
      idx = int'((a - BASE) >> 2);
      if (idx < 3) begin
        m_evt[idx] = d;
        if (m_cnt[idx] < 255) m_cnt[idx]++;
        exp_evt_valid = 1; exp_evt_id = 2'(idx); exp_evt_data = d;
      end else if (idx == 3) begin
        for (int i = 0; i < 3; i++) if (d[8*i]) m_cnt[i] = 0;
      end else begin
        m_wait = int'(d[2:0]); m_irq_en = d[3];
      end
    end
    exp_irq = irq_nxt;
    #1;
  endtask

  task automatic idle(input int n, input bit glitch);
    psel = glitch; penable = glitch;
    for (int i = 0; i < n; i++) tick(0, '0, 0, '0);
  endtask

  task automatic apb(input logic [31:0] a, input bit w, input logic [31:0] d, input int abort_at);
    int lat;
    psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d;
    exp_pready = 0; exp_pslverr = 0; exp_prdata = '0;
    tick(0, a, w, d);
    lat = m_wait;
    penable = 1;
    dut_waits = 0;
    for (int k = 0; k <= lat; k++) begin
      if (k == abort_at) begin
        psel = 0; penable = 0;
        tick(0, a, w, d);
        return;
      end
      if (k == lat) begin
        exp_pready = 1;
        exp_pslverr = is_err(a);
        exp_prdata = (!w && !is_err(a)) ? model_read(a) : '0;
        #2;
        last_rdata = prdata; last_err = pslverr;
        tick(1, a, w, d);
      end else begin
        #2;
        if (pready === 1'b0) dut_waits++;
        tick(0, a, w, d);
      end
    end
    exp_pready = 0; exp_pslverr = 0; exp_prdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_wait = 0;
    chk_en = 1;
    #3;
    idle(2, 0);
    reset = 1;
    idle(2, 1);

    // single event write with no wait states
    apb(BASE + 32'h4, 1, 32'h1234, -1);
    check("req033_waits", dut_waits, 0);
    check("req033_err", {31'h0, last_err}, 32'h0);
    check("req033_valid", {31'h0, evt_valid}, 32'h1);
    check("req033_id", {30'h0, evt_id}, 32'h1);
    check("req033_data", evt_data, 32'h1234);
    apb(BASE + 32'hC, 0, '0, -1);
    check("req033_status", last_rdata, 32'h0000_0100);

    // three wait states
    apb(BASE + 32'h10, 1, 32'h3, -1);
    apb(BASE + 32'h4, 0, '0, -1);
    check("req034_waits", dut_waits, 3);
    check("req034_rdata", last_rdata, 32'h1234);

    // error responses
    apb(BASE + 32'h14, 0, '0, -1);
    check("req035_rd_err", {31'h0, last_err}, 32'h1);
    check("req035_rd_data", last_rdata, 32'h0);
    apb(BASE + 32'h2, 1, 32'hFFFF_FFFF, -1);
    check("req035_wr_err", {31'h0, last_err}, 32'h1);
    idle(1, 0);

    // abort after one access cycle, then a normal transfer
    apb(BASE + 32'h10, 1, 32'h2, -1);
    apb(BASE + 32'h0, 1, 32'hDEAD_BEEF, 1);
    idle(3, 0);
    apb(BASE + 32'h0, 0, '0, -1);
    check("req037_no_store", last_rdata, 32'h0);
    apb(BASE + 32'h0, 1, 32'hA5A5_0001, -1);
    check("req037_pulse", {31'h0, evt_valid}, 32'h1);

    // saturation, W1C and irq fall
    apb(BASE + 32'h10, 1, 32'h8, -1);
    apb(BASE + 32'hC, 1, 32'h0001_0101, -1);
    for (int i = 0; i < 256; i++) apb(BASE + 32'h0, 1, $urandom, -1);
    apb(BASE + 32'hC, 0, '0, -1);
    check("req036_sat", last_rdata, 32'h0000_00FF);
    idle(1, 0);
    check("req036_irq_on", {31'h0, irq}, 32'h1);
    apb(BASE + 32'hC, 1, 32'h1, -1);
    check("req036_irq_hold", {31'h0, irq}, 32'h1);
    idle(1, 0);
    check("req036_irq_fall", {31'h0, irq}, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r, ab;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r <= 4) a = BASE + 32'(4 * r);
      else if (r == 5) a = BASE + 32'(4 * $urandom_range(0, 4) + $urandom_range(1, 3));
      else if (r == 6) a = BASE + 32'h14 + 32'(4 * $urandom_range(0, 3));
      else a = BASE + 32'(4 * (r - 7));
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, m_wait) : -1;
      apb(a, $urandom_range(0, 1) == 1, $urandom, ab);
      idle($urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    // reset during the wait phase of an EVT_C write
    apb(BASE + 32'h10, 1, 32'h0, -1);
    apb(BASE + 32'h8, 1, 32'h55, -1);
    apb(BASE + 32'h10, 1, 32'h5, -1);
    psel = 1; penable = 0; paddr = BASE + 32'h8; pwrite = 1; pwdata = 32'hCAFE_F00D;
    tick(0, paddr, 1, pwdata);
    penable = 1;
    tick(0, paddr, 1, pwdata);
    tick(0, paddr, 1, pwdata);
    #2;
    reset = 0;
    model_reset();
    #1;
    check("req038_pready", {31'h0, pready}, 32'h0);
    check("req038_valid", {31'h0, evt_valid}, 32'h0);
    check("req038_data", evt_data, 32'h0);
    check("req038_irq", {31'h0, irq}, 32'h0);
    psel = 0; penable = 0;
    tick(0, '0, 0, '0);
    tick(0, '0, 0, '0);
    reset = 1;
    idle(2, 0);
    apb(BASE + 32'h8, 0, '0, -1);
    check("req038_evt_c", last_rdata, 32'h0);
    apb(BASE + 32'hC, 0, '0, -1);
    check("req038_status", last_rdata, 32'h0);
    idle(2, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_event_completer.md
APB_EVENT_COMPLETER -- requirements
Module: apb_event_completer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: base of the 5-word register window.
REQ-002 Parameter WAIT_DEFAULT, default 3'd0: reset value of CFG.WAIT (wait states per transfer).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 apb_psel_i  input  1  APB select.
REQ-006 apb_penable_i  input  1  APB enable (access phase).
REQ-007 apb_paddr_i  input  32  byte address.
REQ-008 apb_pwrite_i  input  1  1 = write, 0 = read.
REQ-009 apb_pwdata_i  input  32  write data.
REQ-010 apb_prdata_o  output  32  read data; valid only while apb_pready_o=1 on a read, else 0.
REQ-011 apb_pready_o  output  1  transfer-complete strobe.
REQ-012 apb_pslverr_o  output  1  error response; valid only with apb_pready_o=1, else 0.
REQ-013 evt_valid_o  output  1  one-cycle pulse per accepted event write.
REQ-014 evt_id_o  output  2  channel of pulsed event: 0=A, 1=B, 2=C.
REQ-015 evt_data_o  output  32  data of pulsed event.
REQ-016 irq_o  output  1  level interrupt.

Function
REQ-017 Register map (offset from BASE_ADDR): 0x00 EVT_A, 0x04 EVT_B, 0x08 EVT_C (RW, last written data), 0x0C STATUS ({8'h0, cnt_c, cnt_b, cnt_a}; write = W1C per byte, data bit 0/8/16 clears cnt_a/b/c), 0x10 CFG ([2:0] WAIT, [3] IRQ_EN, rest read 0, write ignored).
REQ-018 FSM states: IDLE, ACCESS.
REQ-019 IDLE -> ACCESS when psel=1 and penable=0 (setup); latch paddr, pwrite, pwdata; load wait counter with CFG.WAIT.
REQ-020 In ACCESS with psel=1 and penable=1: counter != 0 -> apb_pready_o=0, decrement; counter == 0 -> apb_pready_o=1 (combinational from state and counter).
REQ-021 Transfer completes on the edge where psel & penable & apb_pready_o; side effects occur on that edge only; FSM returns to IDLE.
REQ-022 Latency: WAIT=0 -> pready in first access cycle; each WAIT unit adds exactly one cycle; max 7.
REQ-023 Error (pslverr=1 with pready, no side effect, prdata=0): paddr outside window, or paddr[1:0] != 0.
REQ-024 Completed write to EVT_x: store data; saturating 8-bit cnt_x increments (255 holds at 255); next cycle evt_valid_o=1, evt_id_o=x, evt_data_o=data; otherwise evt_valid_o=0 and evt_id_o/evt_data_o hold last value.
REQ-025 Back-to-back event writes (setup immediately after completion) produce one pulse each, no loss.
REQ-026 Reads return register contents sampled in the completing cycle; reads have no side effects.
REQ-027 psel falling in ACCESS before completion: abort to IDLE, no side effect, no pulse, pready stays 0.
REQ-028 CFG.WAIT change takes effect from the next setup phase, never the in-flight transfer.
REQ-029 irq_o = CFG.IRQ_EN & (cnt_a|cnt_b|cnt_c != 0), registered (one cycle after source change).
REQ-030 psel=1 with penable=1 while IDLE (no setup seen): ignored, pready=0.

Reset
REQ-031 reset=0 asynchronously forces: FSM IDLE, counters 0, EVT_A/B/C 0, CFG.WAIT=WAIT_DEFAULT, CFG.IRQ_EN=0, all outputs 0.
REQ-032 reset asserted mid-transfer discards the transfer; after release a fresh setup phase is required.

Verification
REQ-033 WAIT=0, write 0x1234 to EVT_B -> pready in first access cycle, pslverr=0; next cycle evt_valid_o=1, evt_id_o=1, evt_data_o=0x1234; STATUS read = 0x0000_0100.
REQ-034 Write CFG=0x3, then read EVT_B -> pready low for 3 access cycles, high on the 4th, prdata=0x1234.
REQ-035 Read 0x14 and write 0x02 -> each completes with pready=1, pslverr=1, prdata=0, no register or pulse change.
REQ-036 256 writes to EVT_A -> cnt_a=255; write STATUS 0x1 -> cnt_a=0, cnt_b/cnt_c unchanged; with IRQ_EN=1, irq_o falls one cycle later.
REQ-037 CFG.WAIT=2, drop psel after first access cycle -> no side effect, no evt pulse; following transfer completes normally.
REQ-038 Assert reset during the wait phase of an EVT_C write -> all outputs 0 immediately, EVT_C=0, cnt_c=0, no pulse after release.
